// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the I/D cache memory-port arbiter.
// Line/address widths match the cacheline adaptor.
package arb_types;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/cache_mem_arbiter_pick.sv
// Tie-break between I-side and D-side line requests.
// ARB_RR_EN: alternate on ties; otherwise D-side always wins.
module arb_pick
  import arb_types::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  req_id_t last_served,
  output logic    grant_valid,
  output req_id_t grant_id
);

  assign grant_valid = i_req | d_req;

`ifdef ARB_RR_EN
  always_comb begin
    grant_id = REQ_D;
    if (i_req && d_req)
      grant_id = (last_served == REQ_D) ? REQ_I : REQ_D;
    else if (i_req)
      grant_id = REQ_I;
  end
`else
  logic unused_last;
  assign unused_last = last_served;

  // D wins ties so a stalled MEM stage never waits behind fetch
  assign grant_id = d_req ? REQ_D : REQ_I;
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one cacheline memory port between I-cache and D-cache.
// Optional ARB_RR_EN: round-robin tie-break instead of D priority.
module cache_mem_arbiter
  import arb_types::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  state_t      state;
  state_t      state_nxt;
  logic        d_req;
  logic        grant_valid;
  req_id_t     grant_id;
  req_id_t     last_served;
  logic        gnt_i;
  logic        gnt_d;
  logic [LINE_W-1:0] i_line;
  logic [LINE_W-1:0] d_line;

  assign d_req = d_read | d_write;
  assign gnt_i = (state == GRANT_I);
  assign gnt_d = (state == GRANT_D);

  arb_pick u_pick (
    .i_req       (i_read),
    .d_req       (d_req),
    .last_served (last_served),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_valid)
          state_nxt = (grant_id == REQ_D) ? GRANT_D : GRANT_I;
      end
      GRANT_I: if (pmem_resp) state_nxt = RELEASE;
      GRANT_D: if (pmem_resp) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Write wins if D-side illegally asserts both read and write
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    pmem_wdata = '0;
    unique case (1'b1)
      gnt_i: begin
        pmem_read = 1'b1;
        pmem_addr = i_addr;
      end
      gnt_d: begin
        pmem_write = d_write;
        pmem_read  = ~d_write;
        pmem_addr  = d_addr;
        pmem_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  assign i_resp = gnt_i & pmem_resp;
  assign d_resp = gnt_d & pmem_resp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_line <= '0;
      d_line <= '0;
    end else begin
      if (i_resp) i_line <= pmem_rdata;
      if (d_resp) d_line <= pmem_rdata;
    end
  end

  assign i_rdata = i_resp ? pmem_rdata : i_line;
  assign d_rdata = d_resp ? pmem_rdata : d_line;

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_served <= REQ_D;
    else if (i_resp) last_served <= REQ_I;
    else if (d_resp) last_served <= REQ_D;
  end
`else
  assign last_served = REQ_D;
`endif

`ifndef SYNTHESIS
  a_d_rw_excl: assert property (
    @(posedge clk) disable iff (!rst) !(d_read && d_write)
  );
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized scoreboard bench for cache_mem_arbiter.
// Drivers push expected transactions; a negedge monitor checks them.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read, d_read, d_write;
  logic [31:0]  i_addr, d_addr;
  logic [255:0] d_wdata;
  logic [255:0] i_rdata, d_rdata;
  logic         i_resp, d_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_addr;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] data;
  } d_txn_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] i_q[$];
  d_txn_t      d_q[$];
  logic [255:0] ref_mem[logic [31:0]];
  logic [255:0] phys[logic [31:0]];

  logic         mon_en = 1'b0;
  int           mst = 0;
  logic         g_d = 1'b0;
  logic         last_d_srv = 1'b1;
  logic [255:0] last_i = '0;
  logic [255:0] last_d = '0;

  function automatic logic [255:0] init_line(logic [31:0] a);
    if (a == 32'h40) return {32{8'hA5}};
    return {8{a ^ 32'hC3C3_0000}};
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [255:0] ref_read(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  task automatic chk(string n, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic reset_model();
    i_q.delete();
    d_q.delete();
    mst = 0;
    last_d_srv = 1'b1;
    last_i = '0;
    last_d = '0;
  endtask

  // memory: random latency, stray responses when idle, garbage rdata
  logic         m_busy = 1'b0;
  int           m_cnt;
  logic [31:0]  m_a;
  logic         m_wr;
  logic [255:0] m_d;

  initial begin
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      pmem_resp = 1'b0;
      pmem_rdata = rnd_line();
      if (m_busy) begin
        if (m_cnt == 0) begin
          pmem_resp = 1'b1;
          if (m_wr) phys[m_a] = m_d;
          else pmem_rdata = phys.exists(m_a) ? phys[m_a] : init_line(m_a);
          m_busy = 1'b0;
        end else m_cnt--;
      end else if (pmem_read || pmem_write) begin
        m_busy = 1'b1;
        m_cnt = $urandom_range(0, 3);
        m_a = pmem_addr;
        m_wr = pmem_write;
        m_d = pmem_wdata;
      end else if ($urandom_range(0, 5) == 0) begin
        pmem_resp = 1'b1;
      end
    end
  end

  // monitor / reference model: one grant at a time, resp, then a dead cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (!i_resp) chk("i_hold", i_rdata, last_i);
      if (!d_resp) chk("d_hold", d_rdata, last_d);
      case (mst)
        0: begin
          chk("idle_pmem", {pmem_read, pmem_write}, 2'b00);
          chk("idle_resp", {i_resp, d_resp}, 2'b00);
          if (i_read || d_read || d_write) begin
            if (i_read && (d_read || d_write)) begin
`ifdef ARB_RR_EN
              g_d = !last_d_srv;
`else
              g_d = 1'b1;
`endif
            end else g_d = !i_read;
            mst = 1;
          end
        end
        1: begin
          if ((!g_d && i_q.size() == 0) || (g_d && d_q.size() == 0)) begin
            errors++;
            $display("FAIL grant_q no pending txn for side %0d", g_d);
            mst = 0;
          end else if (!g_d) begin
            chk("i_pmem", {pmem_read, pmem_write, pmem_addr},
                {1'b1, 1'b0, i_q[0]});
            chk("i_wdata", pmem_wdata, '0);
            if (pmem_resp) begin
              chk("i_resp", {i_resp, d_resp}, 2'b10);
              chk("i_rdata", i_rdata, ref_read(i_q[0]));
              last_i = pmem_rdata;
              last_d_srv = 1'b0;
              void'(i_q.pop_front());
              mst = 2;
            end else chk("i_wait", {i_resp, d_resp}, 2'b00);
          end else begin
            chk("d_pmem", {pmem_read, pmem_write, pmem_addr},
                {!d_q[0].wr, d_q[0].wr, d_q[0].addr});
            if (d_q[0].wr) chk("d_wdata", pmem_wdata, d_q[0].data);
            if (pmem_resp) begin
              chk("d_resp", {i_resp, d_resp}, 2'b01);
              if (d_q[0].wr) begin
                ref_mem[d_q[0].addr] = d_q[0].data;
                chk("d_wr_rdata", d_rdata, pmem_rdata);
              end else chk("d_rdata", d_rdata, ref_read(d_q[0].addr));
              last_d = pmem_rdata;
              last_d_srv = 1'b1;
              void'(d_q.pop_front());
              mst = 2;
            end else chk("d_wait", {i_resp, d_resp}, 2'b00);
          end
        end
        default: begin
          chk("rel_pmem", {pmem_read, pmem_write}, 2'b00);
          chk("rel_resp", {i_resp, d_resp}, 2'b00);
          mst = 0;
        end
      endcase
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i_txn(logic [31:0] a);
    int n;
    @(posedge clk);
    #1;
    i_read = 1'b1;
    i_addr = a;
    i_q.push_back(a);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i_resp && n < 400);
    if (!i_resp) begin
      errors++;
      $display("FAIL i_timeout addr=%h", a);
    end
    @(posedge clk);
    #1;
    i_read = 1'b0;
    i_addr = $urandom;
  endtask

  task automatic d_txn(logic [31:0] a, logic wr, logic [255:0] data);
    int n;
    d_txn_t t;
    @(posedge clk);
    #1;
    d_read = !wr;
    d_write = wr;
    d_addr = a;
    d_wdata = data;
    t.addr = a;
    t.wr = wr;
    t.data = data;
    d_q.push_back(t);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_resp && n < 400);
    if (!d_resp) begin
      errors++;
      $display("FAIL d_timeout addr=%h", a);
    end
    @(posedge clk);
    #1;
    d_read = 1'b0;
    d_write = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    return {23'd0, 4'($urandom_range(0, 15)), 5'd0};
  endfunction

  task automatic check_reset_outs(string n);
    chk({n, "_pmem"}, {pmem_read, pmem_write, pmem_addr},
        {1'b0, 1'b0, 32'd0});
    chk({n, "_wdata"}, pmem_wdata, '0);
    chk({n, "_resp"}, {i_resp, d_resp}, 2'b00);
    chk({n, "_irdata"}, i_rdata, '0);
    chk({n, "_drdata"}, d_rdata, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    i_read = 1'b0;
    d_read = 1'b0;
    d_write = 1'b0;
    i_addr = '0;
    d_addr = '0;
    d_wdata = '0;
    idle(2);
    check_reset_outs("por");
    rst = 1'b1;
    reset_model();
    mon_en = 1'b1;

    i_txn(32'h40);
    idle(3);
    d_txn(32'h1000, 1'b1, {8{32'h1234_5678}});
    idle(3);
    i_txn(32'h1000);
    idle(3);
    fork
      i_txn(32'h80);
      d_txn(32'hC0, 1'b0, rnd_line());
    join
    idle(3);
    repeat (3) begin
      fork
        i_txn(rnd_addr());
        d_txn(rnd_addr(), 1'($urandom), rnd_line());
      join
    end
    idle(3);

    // reset during a D grant, then a stale memory response
    mon_en = 1'b0;
    d_read = 1'b1;
    d_addr = 32'h2000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pmem_read && n < 20);
    chk("rst_pre_grant", pmem_read, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outs("rst_mid");
    d_read = 1'b0;
    idle(2);
    check_reset_outs("rst_hold");
    rst = 1'b1;
    reset_model();
    mon_en = 1'b1;
    idle(8);

    fork
      begin
        for (int k = 0; k < 60; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          i_txn(rnd_addr());
        end
      end
      begin
        for (int k = 0; k < 60; k++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          d_txn(rnd_addr(), 1'($urandom), rnd_line());
        end
      end
    join
    idle(6);
    chk("q_drained", {i_q.size() == 0, d_q.size() == 0}, 2'b11);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
